// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// be_merge is sized for the widest supported XLEN; callers cast to their width.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int MAX_XLEN = 512;

    function automatic logic [MAX_XLEN-1:0] be_merge(
        input logic [MAX_XLEN-1:0]   old_val,
        input logic [MAX_XLEN-1:0]   new_val,
        input logic [MAX_XLEN/8-1:0] be
    );
        logic [MAX_XLEN-1:0] res;
        res = old_val;
        for (int b = 0; b < MAX_XLEN/8; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear engine: walks the array one register per cycle.
//
// state    | meaning
// RF_IDLE  | normal operation, clear_req starts a sweep from register 0
// RF_CLEAR | zeroing register clr_addr this cycle; returns to idle after NREGS-1
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (clear_req) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                    end
                end
                RF_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) state <= RF_IDLE;
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_en   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with byte-enable writes, write-to-read
// bypass, pending-write scoreboard and a sequential clear engine.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int NRPORTS  = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic [XLEN/8-1:0]       wr_be,
    input  logic [NRPORTS*AW-1:0]   rd_addr,
    output logic [NRPORTS*XLEN-1:0] rd_data,
    output logic [NRPORTS-1:0]      rd_pending,
    input  logic                    pend_set,
    input  logic [AW-1:0]           pend_addr,
    input  logic                    clear_req,
    output logic                    busy
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending;
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic             wr_act;
    logic [XLEN-1:0]  wr_merged;

    rf_clear_seq #(.NREGS(NREGS)) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // wr_ok: a write is accepted at all; wr_act: it also lands in the array
    assign wr_ok     = wr_en && !busy;
    assign wr_act    = wr_ok && !((ZERO_REG != 0) && (wr_addr == '0));
    assign wr_merged = XLEN'(be_merge(MAX_XLEN'(mem[wr_addr]), MAX_XLEN'(wr_data),
                                      (MAX_XLEN/8)'(wr_be)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            pending <= '0;
        end else if (clr_en) begin
            mem[clr_addr]     <= '0;
            pending[clr_addr] <= 1'b0;
        end else begin
            if (wr_act) mem[wr_addr] <= wr_merged;
            if (wr_ok) pending[wr_addr] <= 1'b0;
            // a set on the same address overrides the clear: a new producer was issued
            if (pend_set && !((ZERO_REG != 0) && (pend_addr == '0)))
                pending[pend_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NRPORTS; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            zero_hit;
        logic            byp_hit;
        logic [XLEN-1:0] stored;

        assign ra       = rd_addr[i*AW +: AW];
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);
        assign byp_hit  = (BYPASS != 0) && wr_ok && (wr_addr == ra) && !zero_hit;
        assign stored   = zero_hit ? '0 : mem[ra];

        assign rd_data[i*XLEN +: XLEN] = byp_hit
            ? XLEN'(be_merge(MAX_XLEN'(stored), MAX_XLEN'(wr_data), (MAX_XLEN/8)'(wr_be)))
            : stored;
        assign rd_pending[i] = pending[ra] && !byp_hit && !zero_hit;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic
// compared against an array-based behavioural model.
module tb_reg_file_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN/8-1:0] wr_be;
    logic [NRP*AW-1:0] rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]    rd_pending;
    logic              pend_set;
    logic [AW-1:0]     pend_addr;
    logic              clear_req;
    logic              busy;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRPORTS(NRP), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .clear_req  (clear_req),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [XLEN-1:0] m_mem [NREGS];
    logic            m_pend [NREGS];
    int              m_clr_left;
    int              m_clr_idx;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [XLEN-1:0] byte_mask(input logic [XLEN/8-1:0] be);
        logic [XLEN-1:0] m;
        m = '0;
        for (int b = 0; b < XLEN/8; b++) if (be[b]) m = m | (64'hFF << (8*b));
        return m;
    endfunction

    function automatic logic write_now(input int a);
        return (m_clr_left == 0) && wr_en && (int'(wr_addr) == a) && (a != 0);
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input int a);
        logic [XLEN-1:0] v;
        logic [XLEN-1:0] m;
        if (a == 0) return '0;
        v = m_mem[a];
        if (write_now(a)) begin
            m = byte_mask(wr_be);
            v = (v & ~m) | (wr_data & m);
        end
        return v;
    endfunction

    function automatic logic exp_pend(input int a);
        if (a == 0) return 1'b0;
        return m_pend[a] && !write_now(a);
    endfunction

    task automatic model_edge();
        logic [XLEN-1:0] m;
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_clr_left = 0;
        end else if (m_clr_left > 0) begin
            m_mem[m_clr_idx]  = '0;
            m_pend[m_clr_idx] = 1'b0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (clear_req) begin
                m_clr_left = NREGS;
                m_clr_idx  = 0;
            end
            if (wr_en && wr_addr != 0) begin
                m = byte_mask(wr_be);
                m_mem[wr_addr] = (m_mem[wr_addr] & ~m) | (wr_data & m);
            end
            if (wr_en) m_pend[wr_addr] = 1'b0;
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < NRP; p++) begin
            int a;
            a = int'(rd_addr[p*AW +: AW]);
            chk_eq($sformatf("rd_data[%0d]@x%0d", p, a), rd_data[p*XLEN +: XLEN], exp_rd(a));
            chk_eq($sformatf("rd_pending[%0d]@x%0d", p, a), 64'(rd_pending[p]), 64'(exp_pend(a)));
        end
        chk_eq("busy", 64'(busy), 64'(m_clr_left > 0));
    endtask

    // called at negedge with inputs already set; returns at the following negedge
    task automatic tick(input bit do_chk);
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
        pend_set = 0; pend_addr = '0; clear_req = 0;
    endtask

    task automatic write_reg(input int a, input logic [XLEN-1:0] d, input logic [7:0] be);
        idle_inputs();
        wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        tick(1);
        wr_en = 0;
    endtask

    task automatic fill_all();
        for (int a = 1; a < NREGS; a++)
            write_reg(a, {$urandom(), $urandom()} | 64'h1, 8'hFF);
    endtask

    task automatic read_all_zero(input string tag);
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(NREGS - 1 - a), AW'(a)};
            #1;
            chk_eq(tag, rd_data[XLEN-1:0], '0);
            chk_eq(tag, rd_data[2*XLEN-1:XLEN], '0);
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_idx  = 0;
        idle_inputs();
        rd_addr = '0;
        rst = 0;
        @(negedge clk);
        tick(0);
        tick(1);
        rst = 1;

        // reset state on every address
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            chk_eq("reset_rd", rd_data, '0);
            chk_eq("reset_pend", 64'(rd_pending), 0);
            tick(1);
        end

        // partial byte-enable write with bypass
        write_reg(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr_en = 1; wr_addr = 5; wr_data = 64'h1122_3344_5566_7788; wr_be = 8'h0F;
        rd_addr = {AW'(0), AW'(5)};
        #1;
        chk_eq("be_bypass", rd_data[XLEN-1:0], 64'hFFFF_FFFF_5566_7788);
        tick(1);
        wr_en = 0;
        #1;
        chk_eq("be_stored", rd_data[XLEN-1:0], 64'hFFFF_FFFF_5566_7788);
        tick(1);

        // writes to x0 are discarded
        wr_en = 1; wr_addr = 0; wr_data = 64'hDEAD; wr_be = 8'hFF;
        rd_addr = {AW'(0), AW'(0)};
        #1;
        chk_eq("x0_same_cycle", rd_data[XLEN-1:0], '0);
        tick(1);
        wr_en = 0;
        #1;
        chk_eq("x0_after", rd_data[XLEN-1:0], '0);
        tick(1);

        // scoreboard
        pend_set = 1; pend_addr = 7;
        tick(1);
        pend_set = 0;
        rd_addr = {AW'(7), AW'(0)};
        #1;
        chk_eq("pend_set", 64'(rd_pending[1]), 1);
        tick(1);
        wr_en = 1; wr_addr = 7; wr_data = 64'h77; wr_be = 8'hFF;
        #1;
        chk_eq("pend_masked_by_write", 64'(rd_pending[1]), 0);
        tick(1);
        pend_set = 1; pend_addr = 7;
        tick(1);
        idle_inputs();
        #1;
        chk_eq("pend_set_wins", 64'(rd_pending[1]), 1);
        tick(1);

        // full clear; lost write and repeated clear_req during the sweep
        fill_all();
        clear_req = 1;
        tick(1);
        clear_req = 0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            idle_inputs();
            clear_req = (cnt == 10);
            if (cnt == 5) begin
                wr_en = 1; wr_addr = 2; wr_data = 64'hABCD; wr_be = 8'hFF;
                pend_set = 1; pend_addr = 2;
            end
            tick(1);
            cnt++;
        end
        chk_eq("clear_busy_cycles", 64'(cnt), 64'(NREGS));
        idle_inputs();
        read_all_zero("after_clear");
        rd_addr = {AW'(2), AW'(2)};
        #1;
        chk_eq("clear_pend_x2", 64'(rd_pending), 0);
        tick(1);

        // reset in the middle of a clear at counter 10
        fill_all();
        pend_set = 1; pend_addr = 20;
        tick(1);
        idle_inputs();
        clear_req = 1;
        tick(1);
        clear_req = 0;
        for (int i = 0; i < 10; i++) tick(1);
        rst = 0;
        tick(1);
        rst = 1;
        #1;
        chk_eq("midclear_busy", 64'(busy), 0);
        tick(1);
        read_all_zero("midclear_reset");

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(199) != 0);
            wr_en     = $urandom_range(1);
            wr_addr   = AW'($urandom_range(NREGS - 1));
            wr_data   = {$urandom(), $urandom()};
            wr_be     = 8'($urandom());
            pend_set  = ($urandom_range(2) == 0);
            pend_addr = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(NREGS - 1));
            clear_req = ($urandom_range(79) == 0);
            for (int p = 0; p < NRP; p++)
                rd_addr[p*AW +: AW] = $urandom_range(1) ? wr_addr : AW'($urandom_range(NREGS - 1));
            tick(1);
        end
        rst = 1;
        idle_inputs();
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
